// File: rtl/motor_cmd_sequencer_if.sv
// PS drive command bundle plus the sequencer outputs toward the steering mixer.
// master = command source / observer, slave = motor_cmd_sequencer.
interface motor_cmd_sequencer_if;
    logic       ps_valid;
    logic [6:0] ps_acc;
    logic [7:0] ps_ste;
    logic       btn_brk;
    logic [6:0] acc_out;
    logic [7:0] ste_out;
    logic       brk_out;
    logic       fault;
    logic [2:0] state;

    modport master (
        output ps_valid, ps_acc, ps_ste, btn_brk,
        input  acc_out, ste_out, brk_out, fault, state
    );

    modport slave (
        input  ps_valid, ps_acc, ps_ste, btn_brk,
        output acc_out, ste_out, brk_out, fault, state
    );
endinterface

// File: rtl/motor_cmd_sequencer.sv
// Drive command sequencer: slew-limited accel, brake priority, command watchdog.
// Define SOFT_STOP_EN to ramp down on watchdog timeout instead of hard-braking.
module motor_cmd_sequencer #(
    parameter int RAMP_DIV  = 80,
    parameter int RAMP_STEP = 1,
    parameter int WDT_TICKS = 800,
    parameter int BRK_HOLD  = 400,
    parameter int ACC_MAX   = 100
) (
    input  logic                 clk_8_bufg,
    input  logic                 n_rst,
    motor_cmd_sequencer_if.slave bus
);
    localparam int DW = $clog2(RAMP_DIV + 1);
    localparam int WW = $clog2(WDT_TICKS + 1);
    localparam int HW = $clog2(BRK_HOLD + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(RAMP_DIV - 1);
    localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BRK_HOLD - 1);
    localparam logic [6:0]    ACC_LIM   = 7'(ACC_MAX);
    localparam logic [6:0]    STEP      = 7'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_BRAKE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        r_state;
    logic [6:0]    r_acc;
    logic [6:0]    r_target;
    logic [7:0]    r_ste;
    logic          r_brk;
    logic          r_fault;
    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_div;
    logic [WW-1:0] r_wdt;
    logic [HW-1:0] r_hold;

    logic [6:0]    w_cmd_acc;
    logic [6:0]    w_diff;
    logic [6:0]    w_step;
    logic [6:0]    w_acc_nxt;
    logic [WW-1:0] w_wdt_inc;
    logic          w_up;
    logic          w_active;
    logic          w_tmo;
    logic          w_latch;
    logic          w_land;
    logic          w_ss_exit;

    assign w_cmd_acc = (bus.ps_acc > ACC_LIM) ? ACC_LIM : bus.ps_acc;
    assign w_up      = r_target > r_acc;
    assign w_diff    = w_up ? r_target - r_acc : r_acc - r_target;
    assign w_step    = (w_diff < STEP) ? w_diff : STEP;
    assign w_acc_nxt = w_up ? r_acc + w_step : r_acc - w_step;
    assign w_wdt_inc = (r_wdt == WDT_LAST) ? r_wdt : r_wdt + 1'b1;

    // A soft-stop ramp (fault already set) is not watched and takes no commands.
    assign w_active = (r_state == S_RAMP || r_state == S_HOLD) && !r_fault;
    assign w_tmo    = w_active && !bus.ps_valid && (r_wdt == WDT_LAST);
    assign w_latch  = bus.ps_valid && !r_fault &&
                      (r_state == S_IDLE || r_state == S_RAMP ||
                       r_state == S_HOLD);
    assign w_land   = (r_acc == r_target) ||
                      (r_div == DIV_LAST && w_acc_nxt == r_target);

`ifdef SOFT_STOP_EN
    assign w_ss_exit = r_fault && bus.ps_valid && (bus.ps_acc == 7'd0);
`else
    assign w_ss_exit = 1'b0;
`endif

    always_ff @(posedge clk_8_bufg) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_target <= '0;
            r_ste    <= '0;
            r_brk    <= 1'b0;
            r_fault  <= 1'b0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_div    <= '0;
            r_wdt    <= '0;
            r_hold   <= '0;
        end else begin
            r_sync1 <= bus.btn_brk;
            r_sync2 <= r_sync1;
            if (r_sync2) begin
                r_state  <= S_BRAKE;
                r_acc    <= '0;
                r_ste    <= '0;
                r_brk    <= 1'b1;
                r_target <= '0;
                r_hold   <= '0;
                r_wdt    <= '0;
                r_div    <= '0;
            end else if (w_tmo) begin
                r_fault  <= 1'b1;
                r_target <= '0;
                r_wdt    <= '0;
`ifdef SOFT_STOP_EN
                r_state  <= S_RAMP;
                r_div    <= '0;
`else
                r_state  <= S_FAULT;
                r_acc    <= '0;
                r_ste    <= '0;
                r_brk    <= 1'b1;
`endif
            end else begin
                r_wdt <= w_active ? w_wdt_inc : '0;
                if (w_latch) begin
                    r_target <= w_cmd_acc;
                    r_ste    <= bus.ps_ste;
                    r_wdt    <= '0;
                    r_div    <= '0;
                end
                unique case (r_state)
                    S_IDLE: begin
                        if (w_latch && w_cmd_acc != 7'd0)
                            r_state <= S_RAMP;
                    end
                    S_HOLD: begin
                        if (w_latch && w_cmd_acc != r_acc)
                            r_state <= S_RAMP;
                    end
                    S_RAMP: begin
                        if (w_ss_exit) begin
                            r_state  <= S_IDLE;
                            r_fault  <= 1'b0;
                            r_acc    <= '0;
                            r_target <= '0;
                        end else if (!w_latch) begin
                            if (r_div == DIV_LAST) begin
                                r_acc <= w_acc_nxt;
                                r_div <= '0;
                            end else begin
                                r_div <= r_div + 1'b1;
                            end
                            if (w_land && r_fault) begin
                                r_state <= S_FAULT;
                                r_brk   <= 1'b1;
                                r_ste   <= '0;
                            end else if (w_land) begin
                                r_state <= (r_target != 7'd0) ? S_HOLD : S_IDLE;
                            end
                        end
                    end
                    S_BRAKE: begin
                        // A pending fault survives the brake and is re-entered.
                        if (r_hold == HOLD_LAST) begin
                            r_state <= r_fault ? S_FAULT : S_IDLE;
                            r_brk   <= r_fault;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    S_FAULT: begin
                        if (bus.ps_valid && bus.ps_acc == 7'd0) begin
                            r_state <= S_IDLE;
                            r_fault <= 1'b0;
                            r_brk   <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.acc_out = r_acc;
    assign bus.ste_out = r_ste;
    assign bus.brk_out = r_brk;
    assign bus.fault   = r_fault;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed corners plus random traffic,
// every output compared each cycle against a behavioural model.
module tb_motor_cmd_sequencer;
    localparam int RAMP_DIV  = 4;
    localparam int RAMP_STEP = 1;
    localparam int WDT_TICKS = 64;
    localparam int BRK_HOLD  = 8;
    localparam int ACC_MAX   = 100;

    logic clk_8_bufg = 1'b0;
    logic n_rst      = 1'b0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    bit   started    = 1'b0;
    int   press_left = 0;

    motor_cmd_sequencer_if bus();

    motor_cmd_sequencer #(
        .RAMP_DIV (RAMP_DIV),
        .RAMP_STEP(RAMP_STEP),
        .WDT_TICKS(WDT_TICKS),
        .BRK_HOLD (BRK_HOLD),
        .ACC_MAX  (ACC_MAX)
    ) dut (
        .clk_8_bufg(clk_8_bufg),
        .n_rst     (n_rst),
        .bus       (bus)
    );

    always #5 clk_8_bufg = ~clk_8_bufg;

    initial begin
        #2000000;
        $display("FAIL time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t",
                         nm, got, exp, $time);
        end
    endtask

    // Model: modes use the output encoding (0 idle .. 4 fault).
    int m_mode, m_acc, m_tgt, m_ste, m_brk, m_fault;
    int m_quiet, m_phase, m_rel;
    bit m_d1, m_d2;

    task automatic m_advance();
        int gap;
        if (m_acc != m_tgt) begin
            m_phase++;
            if (m_phase == RAMP_DIV) begin
                m_phase = 0;
                gap = (m_tgt > m_acc) ? m_tgt - m_acc : m_acc - m_tgt;
                if (gap > RAMP_STEP) gap = RAMP_STEP;
                m_acc = (m_tgt > m_acc) ? m_acc + gap : m_acc - gap;
            end
        end
        if (m_acc == m_tgt) begin
            if (m_fault != 0) begin
                m_mode = 4;
                m_brk  = 1;
                m_ste  = 0;
            end else begin
                m_mode = (m_tgt > 0) ? 2 : 0;
            end
        end
    endtask

    always @(posedge clk_8_bufg) begin : model
        bit pressed;
        int cmd;
        int req;
        started = 1'b1;
        if (!n_rst) begin
            m_mode = 0; m_acc = 0; m_tgt = 0; m_ste = 0;
            m_brk = 0; m_fault = 0; m_quiet = 0; m_phase = 0;
            m_rel = 0; m_d1 = 1'b0; m_d2 = 1'b0;
        end else begin
            pressed = m_d2;
            m_d2    = m_d1;
            m_d1    = bus.btn_brk;
            req     = int'(bus.ps_acc);
            cmd     = (req > ACC_MAX) ? ACC_MAX : req;
            if (pressed) begin
                m_mode = 3; m_acc = 0; m_ste = 0; m_brk = 1;
                m_tgt = 0; m_rel = 0; m_quiet = 0;
            end else if (m_mode == 3) begin
                m_rel++;
                if (m_rel == BRK_HOLD) begin
                    m_mode = (m_fault != 0) ? 4 : 0;
                    m_brk  = m_fault;
                end
            end else if (m_mode == 4) begin
                if (bus.ps_valid && req == 0) begin
                    m_mode = 0; m_fault = 0; m_brk = 0;
                end
            end else if (m_fault != 0) begin
                if (bus.ps_valid && req == 0) begin
                    m_mode = 0; m_fault = 0; m_acc = 0; m_tgt = 0;
                end else begin
                    m_advance();
                end
            end else if (bus.ps_valid) begin
                m_tgt = cmd; m_ste = int'(bus.ps_ste);
                m_quiet = 0; m_phase = 0;
                if (m_mode == 0 && cmd > 0) m_mode = 1;
                if (m_mode == 2 && cmd != m_acc) m_mode = 1;
            end else if (m_mode != 0) begin
                m_quiet++;
                if (m_quiet == WDT_TICKS) begin
                    m_quiet = 0; m_fault = 1; m_tgt = 0;
`ifdef SOFT_STOP_EN
                    m_mode = 1; m_phase = 0;
`else
                    m_mode = 4; m_acc = 0; m_ste = 0; m_brk = 1;
`endif
                end else if (m_mode == 1) begin
                    m_advance();
                end
            end
        end
    end

    always @(negedge clk_8_bufg) begin
        if (started) begin
            chk("m_state", int'(bus.state),   m_mode);
            chk("m_acc",   int'(bus.acc_out), m_acc);
            chk("m_ste",   int'(bus.ste_out), m_ste);
            chk("m_brk",   int'(bus.brk_out), m_brk);
            chk("m_fault", int'(bus.fault),   m_fault);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_8_bufg);
    endtask

    task automatic cmd(input int a, input int s);
        bus.ps_valid = 1'b1;
        bus.ps_acc   = 7'(a);
        bus.ps_ste   = 8'(s);
        @(negedge clk_8_bufg);
        bus.ps_valid = 1'b0;
    endtask

    task automatic ramp_to(input int a, input int st);
        cmd(a, 8'h20);
        for (int i = 0; i < 1500; i++) begin
            if (int'(bus.state) == st) break;
            if (i % 32 == 31) cmd(a, 8'h20);
            else cyc(1);
        end
    endtask

    initial begin
        bus.ps_valid = 1'b0;
        bus.ps_acc   = '0;
        bus.ps_ste   = '0;
        bus.btn_brk  = 1'b0;
        n_rst = 1'b0;
        cyc(3);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_acc", int'(bus.acc_out), 0);
        chk("rst_brk", int'(bus.brk_out), 0);
        chk("rst_fault", int'(bus.fault), 0);
        n_rst = 1'b1;
        cyc(1);

        // ramp up to 10
        cmd(10, 8'h20);
        chk("t1_ste", int'(bus.ste_out), 32);
        chk("t1_state", int'(bus.state), 1);
        cyc(39);
        chk("t1_acc39", int'(bus.acc_out), 9);
        cyc(1);
        chk("t1_acc40", int'(bus.acc_out), 10);
        chk("t1_hold", int'(bus.state), 2);

        // clamp to 100 then back down to idle
        ramp_to(120, 2);
        chk("t2_clamp", int'(bus.acc_out), 100);
        chk("t2_hold", int'(bus.state), 2);
        ramp_to(0, 0);
        chk("t2_zero", int'(bus.acc_out), 0);
        chk("t2_idle", int'(bus.state), 0);

        // brake mid-ramp
        cmd(10, 8'h11);
        cyc(9);
        chk("t3_acc", int'(bus.acc_out), 2);
        bus.btn_brk = 1'b1;
        cyc(2);
        chk("t3_brk_e2", int'(bus.brk_out), 0);
        cyc(1);
        chk("t3_brk_e3", int'(bus.brk_out), 1);
        chk("t3_acc_e3", int'(bus.acc_out), 0);
        chk("t3_state", int'(bus.state), 3);
        bus.btn_brk = 1'b0;
        cyc(3);
        cmd(50, 8'h77);
        chk("t3_ign_st", int'(bus.state), 3);
        chk("t3_ign_ste", int'(bus.ste_out), 0);
        cyc(5);
        chk("t3_still", int'(bus.state), 3);
        cyc(1);
        chk("t3_exit", int'(bus.state), 0);
        chk("t3_rel", int'(bus.brk_out), 0);

        // watchdog from HOLD@20
        cmd(10, 8'h05);
        cyc(40);
        cmd(20, 8'h05);
        cyc(39);
        chk("t4_acc19", int'(bus.acc_out), 19);
        cyc(1);
        chk("t4_hold20", int'(bus.state), 2);
        cyc(23);
        chk("t4_pre", int'(bus.fault), 0);
        cyc(1);
        chk("t4_fault", int'(bus.fault), 1);
`ifdef SOFT_STOP_EN
        chk("t5_state", int'(bus.state), 1);
        chk("t5_brk", int'(bus.brk_out), 0);
        cyc(79);
        chk("t5_acc1", int'(bus.acc_out), 1);
        cyc(1);
        chk("t5_acc0", int'(bus.acc_out), 0);
        chk("t5_fstate", int'(bus.state), 4);
        chk("t5_fbrk", int'(bus.brk_out), 1);
`else
        chk("t4_state", int'(bus.state), 4);
        chk("t4_brk", int'(bus.brk_out), 1);
        chk("t4_acc", int'(bus.acc_out), 0);
`endif
        cmd(5, 8'h09);
        chk("t4_ign", int'(bus.state), 4);
        cmd(0, 8'h09);
        chk("t4_exit", int'(bus.state), 0);
        chk("t4_clr", int'(bus.fault), 0);

        // brake and command on the same edge
        bus.btn_brk = 1'b1;
        cyc(2);
        bus.ps_valid = 1'b1;
        bus.ps_acc   = 7'd40;
        bus.ps_ste   = 8'h55;
        cyc(1);
        bus.ps_valid = 1'b0;
        bus.btn_brk  = 1'b0;
        chk("t6_brake", int'(bus.state), 3);
        chk("t6_ste", int'(bus.ste_out), 0);
        cyc(10);
        chk("t6_idle", int'(bus.state), 0);
        chk("t6_acc", int'(bus.acc_out), 0);

        // command coincident with the timeout edge
        cmd(10, 8'h01);
        cyc(40);
        cyc(23);
        cmd(10, 8'h01);
        chk("t6_wdt_st", int'(bus.state), 2);
        chk("t6_wdt_f", int'(bus.fault), 0);
        cyc(63);
        chk("t6_wdt_pre", int'(bus.fault), 0);
        cyc(1);
        chk("t6_wdt_to", int'(bus.fault), 1);
        cmd(0, 8'h01);
        chk("t6_wdt_clr", int'(bus.fault), 0);

        // reset mid-ramp
        cmd(50, 8'h33);
        cyc(10);
        n_rst = 1'b0;
        cyc(1);
        chk("t6_rst_acc", int'(bus.acc_out), 0);
        chk("t6_rst_ste", int'(bus.ste_out), 0);
        chk("t6_rst_st", int'(bus.state), 0);
        n_rst = 1'b1;
        cyc(1);

        for (int i = 0; i < 6000; i++) begin
            bus.ps_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) bus.ps_acc = 7'd0;
            else if ($urandom_range(0, 1) == 0)
                bus.ps_acc = 7'($urandom_range(1, 12));
            else bus.ps_acc = 7'($urandom_range(0, 127));
            bus.ps_ste = 8'($urandom_range(0, 255));
            if (press_left > 0) press_left--;
            else if ($urandom_range(0, 199) == 0)
                press_left = $urandom_range(1, 6);
            bus.btn_brk = (press_left > 0);
            n_rst = ($urandom_range(0, 1999) != 0);
            cyc(1);
        end

        n_rst        = 1'b1;
        bus.ps_valid = 1'b0;
        bus.btn_brk  = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
